mem_byte_sequencer: RTL

Load/store sequencer between the pipeline's memory stage and the byte-wide data memory. Accepts one 8/16/32-bit load or store request at a time. Performs it as consecutive single-byte accesses: one byte per cycle, ascending addresses, little-endian by default. Returns a one-cycle response carrying the assembled and extended load data.

---
 rtl/mem_byte_sequencer_if.sv | 23 ++
 rtl/mem_byte_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_byte_sequencer_if.sv
// rtl/mem_byte_sequencer_if.sv - request/response handshake bundle for mem_byte_sequencer
interface mem_byte_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata
   );
endinterface

// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - serialises 8/16/32-bit loads/stores into byte-wide memory beats
module mem_byte_sequencer #(
   parameter bit BIG_ENDIAN = 1'b0,
   parameter int MEM_BYTES  = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_byte_sequencer_if.slave  bus,
   output logic                 mem_enwr,
   output logic                 mem_rd,
   output logic [31:0]          mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic [7:0]           mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

   state_t      state, state_nx;
   logic        we_q;
   logic        signed_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] asm_q;
   logic [1:0]  beat_q;

   logic [1:0]  last_in;
   logic [1:0]  last_q;
   logic [32:0] end_addr;
   logic        range_err;
   logic [1:0]  byte_sel;
   logic        beat_last;
   logic        accept;
   logic [31:0] ext_data;

   logic        req_ready;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;

   // Index of the final beat: N-1 for N = 1, 2 or 4 (size 3 behaves as a word).
   function automatic logic [1:0] last_beat(input logic [1:0] size);
      case (size)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   assign last_in   = last_beat(bus.req_size);
   assign last_q    = last_beat(size_q);
   // 33-bit sum so an access wrapping past 2^32 is caught as out of range.
   assign end_addr  = {1'b0, bus.req_addr} + {31'd0, last_in};
   assign range_err = end_addr >= 33'(MEM_BYTES);
   // Data byte carried by the current memory beat; big-endian walks the data MSB first.
   assign byte_sel  = BIG_ENDIAN ? (last_q - beat_q) : beat_q;
   assign beat_last = (beat_q == last_q);
   assign accept    = (state == S_IDLE) && bus.req_valid;

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_err   = resp_err;
   assign bus.resp_rdata = resp_rdata;

   // Zero- or sign-extend the assembled load to 32 bits.
   always_comb begin
      ext_data = asm_q;
      case (size_q)
         2'd0:    ext_data = {{24{signed_q & asm_q[7]}}, asm_q[7:0]};
         2'd1:    ext_data = {{16{signed_q & asm_q[15]}}, asm_q[15:0]};
         default: ext_data = asm_q;
      endcase
   end

   // State register; reset aborts any request in flight.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next state plus all handshake and memory-side outputs, decoded from registered state.
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'd0;
      mem_enwr   = 1'b0;
      mem_rd     = 1'b0;
      mem_addr   = 32'd0;
      mem_wdata  = 8'd0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) state_nx = range_err ? S_ERR : S_ACCESS;
         end
         S_ACCESS: begin
            mem_addr  = addr_q + {30'd0, beat_q};
            mem_enwr  = we_q;
            mem_rd    = ~we_q;
            mem_wdata = we_q ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'd0;
            if (beat_last) state_nx = S_DONE;
         end
         S_DONE: begin
            resp_valid = 1'b1;
            resp_rdata = we_q ? 32'd0 : ext_data;
            state_nx   = S_IDLE;
         end
         S_ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Request latch, beat counter and load assembly register.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= 2'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         asm_q    <= 32'd0;
         beat_q   <= 2'd0;
      end else if (accept) begin
         we_q     <= bus.req_we;
         signed_q <= bus.req_signed;
         size_q   <= bus.req_size;
         addr_q   <= bus.req_addr;
         wdata_q  <= bus.req_wdata;
         asm_q    <= 32'd0;
         beat_q   <= 2'd0;
      end else if (state == S_ACCESS) begin
         beat_q <= beat_q + 2'd1;
         if (!we_q) asm_q[{byte_sel, 3'b000} +: 8] <= mem_rdata;
      end
   end

endmodule
